// File: rtl/led_mode1_driver.sv
`default_nettype none
// ============================================================================
//  Module      : led_mode1_driver
//  Description : Heartbeat-shaped PWM brightness envelope for display mode 1.
//                Strong beat, weaker second beat, then a dark rest, repeated.
//                All eight LED pins carry the same registered waveform.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_mode1_driver #(
    parameter int unsigned STEP_FRAMES    = 4,
    parameter int unsigned PEAK1          = 255,
    parameter int unsigned PEAK2          = 192,
    parameter int unsigned REST_STEPS     = 256,
    parameter bit          LED_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] led_out
);

    localparam logic [15:0] c_step_last = 16'(STEP_FRAMES - 1);
    localparam logic [15:0] c_rest_last = 16'(REST_STEPS - 1);
    localparam logic [7:0]  c_peak1     = 8'(PEAK1);
    localparam logic [7:0]  c_peak2     = 8'(PEAK2);

    localparam logic [2:0] c_RISE1 = 3'd0;
    localparam logic [2:0] c_FALL1 = 3'd1;
    localparam logic [2:0] c_RISE2 = 3'd2;
    localparam logic [2:0] c_FALL2 = 3'd3;
    localparam logic [2:0] c_REST  = 3'd4;

    logic [7:0]  r_pwm_cnt;
    logic [15:0] r_frame_cnt;
    logic [15:0] r_rest_cnt;
    logic [7:0]  r_duty;
    logic [2:0]  r_state;
    logic [7:0]  r_led_out;

    logic        w_frame_end;
    logic        w_step_tick;
    logic        w_lit;
    logic [7:0]  w_duty_inc;
    logic [7:0]  w_duty_dec;

    // The step tick coincides with the last clock of a PWM frame, so a new
    // duty only ever applies from the next pwm_cnt==0 onward.
    assign w_frame_end = (r_pwm_cnt == 8'hFF);
    assign w_step_tick = w_frame_end && (r_frame_cnt == c_step_last);
    assign w_lit       = (r_pwm_cnt < r_duty);
    assign w_duty_inc  = r_duty + 8'd1;
    assign w_duty_dec  = r_duty - 8'd1;

    // Free-running 8-bit PWM phase counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pwm_cnt <= 8'd0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
        end
    end

    // Counts completed PWM frames within one brightness step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_cnt <= 16'd0;
        end else if (w_frame_end) begin
            if (r_frame_cnt == c_step_last) begin
                r_frame_cnt <= 16'd0;
            end else begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    // Envelope state machine: ramps duty up/down one count per step tick.
    // Turn-around happens on the step that reaches the peak or zero, so
    // duty never overshoots the peak nor wraps below zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_RISE1;
            r_duty     <= 8'd0;
            r_rest_cnt <= 16'd0;
        end else if (w_step_tick) begin
            case (r_state)
                c_RISE1: begin
                    r_duty <= w_duty_inc;
                    if (w_duty_inc == c_peak1) begin
                        r_state <= c_FALL1;
                    end
                end
                c_FALL1: begin
                    r_duty <= w_duty_dec;
                    if (w_duty_dec == 8'd0) begin
                        r_state <= c_RISE2;
                    end
                end
                c_RISE2: begin
                    r_duty <= w_duty_inc;
                    if (w_duty_inc == c_peak2) begin
                        r_state <= c_FALL2;
                    end
                end
                c_FALL2: begin
                    r_duty <= w_duty_dec;
                    if (w_duty_dec == 8'd0) begin
                        r_state    <= c_REST;
                        r_rest_cnt <= 16'd0;
                    end
                end
                c_REST: begin
                    r_duty <= 8'd0;
                    if (r_rest_cnt == c_rest_last) begin
                        r_state    <= c_RISE1;
                        r_rest_cnt <= 16'd0;
                    end else begin
                        r_rest_cnt <= r_rest_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state    <= c_RISE1;
                    r_duty     <= 8'd0;
                    r_rest_cnt <= 16'd0;
                end
            endcase
        end
    end

    // Registered pin drive; reset holds every LED at its unlit level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_led_out <= {8{LED_ACTIVE_LOW}};
        end else begin
            r_led_out <= {8{w_lit ^ LED_ACTIVE_LOW}};
        end
    end

    assign led_out = r_led_out;

endmodule
`default_nettype wire

// File: tb/tb_led_mode1_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_mode1_driver
//  Description : Self-checking bench for led_mode1_driver. Three instances:
//                defaults, the small override set, and a short-period
//                active-high set used for whole-envelope and reset checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_mode1_driver;

    logic       clk = 1'b0;
    logic       rst_a = 1'b0;
    logic       rst_b = 1'b0;
    logic       rst_c = 1'b0;
    logic [7:0] led_a;
    logic [7:0] led_b;
    logic [7:0] led_c;

    int checks   = 0;
    int failures = 0;

    // Short-envelope instance parameters
    localparam int C_SF = 1;
    localparam int C_P1 = 20;
    localparam int C_P2 = 12;
    localparam int C_RS = 10;
    localparam int C_PERIOD_STEPS = 2*C_P1 + 2*C_P2 + C_RS;

    always #5 clk = ~clk;

    led_mode1_driver dut_a (
        .clk     (clk),
        .rst_n   (rst_a),
        .led_out (led_a)
    );

    led_mode1_driver #(
        .STEP_FRAMES    (1),
        .PEAK1          (4),
        .PEAK2          (2),
        .REST_STEPS     (3),
        .LED_ACTIVE_LOW (1'b1)
    ) dut_b (
        .clk     (clk),
        .rst_n   (rst_b),
        .led_out (led_b)
    );

    led_mode1_driver #(
        .STEP_FRAMES    (C_SF),
        .PEAK1          (C_P1),
        .PEAK2          (C_P2),
        .REST_STEPS     (C_RS),
        .LED_ACTIVE_LOW (1'b0)
    ) dut_c (
        .clk     (clk),
        .rst_n   (rst_c),
        .led_out (led_c)
    );

    // Envelope brightness after k completed steps, from the beat shape:
    // up to p1, down to 0, up to p2, down to 0, then rs steps dark.
    function automatic int duty_after(int k, int p1, int p2, int rs);
        int per;
        int m;
        per = 2*p1 + 2*p2 + rs;
        m   = k % per;
        if (m <= p1)             return m;
        if (m <= 2*p1)           return 2*p1 - m;
        if (m <= 2*p1 + p2)      return m - 2*p1;
        if (m <= 2*p1 + 2*p2)    return 2*p1 + 2*p2 - m;
        return 0;
    endfunction

    // Pin value during clock index idx after reset release (idx 0 is the
    // clock right after release). The pin shows the lit state of the
    // previous clock; clock j is lit when its frame phase < current duty.
    function automatic logic [7:0] exp_led(int idx, int sf, int p1, int p2,
                                           int rs, bit al);
        int  j;
        int  d;
        bit  lit;
        if (idx == 0) return {8{al}};
        j   = idx - 1;
        d   = duty_after(j / (sf*256), p1, p2, rs);
        lit = ((j % 256) < d);
        return {8{lit ^ al}};
    endfunction

    task automatic test_reset;
        int n;
        n = 2 + int'($urandom_range(0, 3));
        rst_a = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            checks++;
            if (led_a !== 8'h00) begin
                failures++;
                $display("FAIL reset_hold led=%h expected=%h", led_a, 8'h00);
            end
        end
        rst_a = 1'b1;
    endtask

    // Starts at clock index 0 immediately after test_reset released rst_a.
    task automatic test_first_ramp;
        logic [7:0] e;
        int lit1;
        int lit11;
        lit1  = 0;
        lit11 = 0;
        for (int i = 0; i < 12*1024; i++) begin
            e = exp_led(i, 4, 255, 192, 256, 1'b0);
            checks++;
            if (led_a !== e) begin
                failures++;
                $display("FAIL ramp_pin idx=%0d led=%h expected=%h", i, led_a, e);
            end
            if (i >= 1025 && i <= 1280 && led_a === 8'hFF) lit1++;
            if (i >= 11*1024+1 && i <= 11*1024+256 && led_a === 8'hFF) lit11++;
            @(posedge clk); #1;
        end
        checks++;
        if (lit1 != 1) begin
            failures++;
            $display("FAIL step1_lit_count got=%0d expected=1", lit1);
        end
        checks++;
        if (lit11 != 11) begin
            failures++;
            $display("FAIL step11_lit_count got=%0d expected=11", lit11);
        end
    endtask

    task automatic test_envelope;
        logic [7:0] e;
        int n;
        int peak_lit;
        int restart_lit;
        int pk_lo;
        int rs_lo;
        peak_lit    = 0;
        restart_lit = 0;
        pk_lo = C_P1*256 + 1;
        rs_lo = (C_PERIOD_STEPS + 1)*256 + 1;
        n = 1 + int'($urandom_range(0, 3));
        rst_c = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            checks++;
            if (led_c !== 8'h00) begin
                failures++;
                $display("FAIL env_reset led=%h expected=%h", led_c, 8'h00);
            end
        end
        rst_c = 1'b1;
        for (int i = 0; i < 2*C_PERIOD_STEPS*256 + 300; i++) begin
            e = exp_led(i, C_SF, C_P1, C_P2, C_RS, 1'b0);
            checks++;
            if (led_c !== e) begin
                failures++;
                $display("FAIL env_pin idx=%0d led=%h expected=%h", i, led_c, e);
            end
            if (i >= pk_lo && i < pk_lo + 256 && led_c === 8'hFF) peak_lit++;
            if (i >= rs_lo && i < rs_lo + 256 && led_c === 8'hFF) restart_lit++;
            @(posedge clk); #1;
        end
        checks++;
        if (peak_lit != C_P1) begin
            failures++;
            $display("FAIL peak_frame_lit got=%0d expected=%0d", peak_lit, C_P1);
        end
        checks++;
        if (restart_lit != 1) begin
            failures++;
            $display("FAIL restart_frame_lit got=%0d expected=1", restart_lit);
        end
    endtask

    task automatic test_mid_reset;
        logic [7:0] e;
        int stop_idx;
        rst_c = 1'b0;
        repeat (1 + int'($urandom_range(0, 2))) @(posedge clk);
        #1;
        rst_c = 1'b1;
        // Land somewhere in the first falling ramp
        stop_idx = int'($urandom_range(C_P1 + 2, 2*C_P1 - 2)) * 256
                 + int'($urandom_range(0, 255));
        for (int i = 0; i < stop_idx; i++) begin
            e = exp_led(i, C_SF, C_P1, C_P2, C_RS, 1'b0);
            checks++;
            if (led_c !== e) begin
                failures++;
                $display("FAIL pre_reset_pin idx=%0d led=%h expected=%h", i, led_c, e);
            end
            @(posedge clk); #1;
        end
        rst_c = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (led_c !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset_unlit led=%h expected=%h", led_c, 8'h00);
        end
        rst_c = 1'b1;
        for (int i = 0; i < 25*256; i++) begin
            e = exp_led(i, C_SF, C_P1, C_P2, C_RS, 1'b0);
            checks++;
            if (led_c !== e) begin
                failures++;
                $display("FAIL post_reset_pin idx=%0d led=%h expected=%h", i, led_c, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_override;
        logic [7:0] e;
        int lit_first;
        lit_first = 0;
        rst_b = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            checks++;
            if (led_b !== 8'hFF) begin
                failures++;
                $display("FAIL ovr_reset led=%h expected=%h", led_b, 8'hFF);
            end
        end
        rst_b = 1'b1;
        for (int i = 0; i < 3*3840 + 10; i++) begin
            e = exp_led(i, 1, 4, 2, 3, 1'b1);
            checks++;
            if (led_b !== e) begin
                failures++;
                $display("FAIL ovr_pin idx=%0d led=%h expected=%h", i, led_b, e);
            end
            // Second period starts at clock 3840 dark, then duty 1 at 4096
            if (i >= 4097 && i < 4097 + 256 && led_b === 8'h00) lit_first++;
            @(posedge clk); #1;
        end
        checks++;
        if (lit_first != 1) begin
            failures++;
            $display("FAIL ovr_period_restart_lit got=%0d expected=1", lit_first);
        end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_first_ramp();
        test_envelope();
        test_mid_reset();
        test_override();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_mode1_driver.md
# led_mode1_driver

Heartbeat-pattern LED driver for display mode 1. Generates an 8-bit PWM brightness envelope shaped like a heartbeat: a strong beat, a weaker second beat, then a dark rest. It then repeats. All eight LEDs carry the same waveform, and the block drives the board LED pins directly from the 12 MHz system clock.

## Interface
- STEP_FRAMES, 4: PWM frames (256 clocks each) per brightness step; 1..65535.
- PEAK1, 255: peak duty of first beat; 1..255.
- PEAK2, 192: peak duty of second beat; 1..255.
- REST_STEPS, 256: length of dark rest, in brightness steps; 1..65535.
- LED_ACTIVE_LOW, 0: 1 inverts all outputs. An LED is "lit" at 1 when this is 0, and at 0 when this is 1.
- clk  in  1  system clock, 12 MHz.
- rst_n  in  1  reset. Synchronous, active-low; one clock domain.
- led_out  out  8  LED drive; all bits identical, registered.

## Operation
- pwm_cnt is an 8-bit counter that increments every clk and wraps 255→0.
- frame_cnt counts completed PWM frames. It advances when pwm_cnt==255 and wraps at STEP_FRAMES-1.
- step_tick is asserted for one clk when pwm_cnt==255 and frame_cnt==STEP_FRAMES-1.
- duty is an 8-bit register. The lit condition is pwm_cnt < duty.
  - duty 0 means never lit.
  - duty d means lit for d of every 256 clocks.
- led_out is registered. All 8 bits are driven to the lit condition, XORed with LED_ACTIVE_LOW.
- State machine RISE1, FALL1, RISE2, FALL2, REST. It acts only on step_tick:
  - RISE1: duty←duty+1. If duty+1==PEAK1, go to FALL1.
  - FALL1: duty←duty-1. If duty-1==0, go to RISE2.
  - RISE2: duty←duty+1. If duty+1==PEAK2, go to FALL2.
  - FALL2: duty←duty-1. If duty-1==0, go to REST and set rest_cnt←0.
  - REST: duty stays 0. rest_cnt←rest_cnt+1. If rest_cnt==REST_STEPS-1, go to RISE1 and set rest_cnt←0.
- duty never wraps: it never exceeds the current peak and never goes below 0.
- Period in steps is 2·PEAK1 + 2·PEAK2 + REST_STEPS, which is 1150 at defaults.
- Period in clocks is steps × STEP_FRAMES × 256, which is 1,177,600 at defaults (≈98.13 ms).

## Timing
- Reset: while rst_n==0 at a clk edge, the block clears:
  - pwm_cnt, frame_cnt, rest_cnt and duty to 0;
  - state to RISE1;
  - led_out to the unlit level (8'h00 when LED_ACTIVE_LOW=0, 8'hFF when 1).
- Reset mid-pattern restarts from RISE1 with duty 0. No residual brightness remains.
- First clock after release: pwm_cnt=0.
- First step_tick lands on the edge that ends clock index STEP_FRAMES·256-1 after release (1023 at defaults). duty becomes 1 at that edge.
- led_out has one clk of latency from (pwm_cnt, duty) to the pin.
- A duty change takes effect at the next pwm_cnt==0. duty changes only on step_tick, which coincides with pwm_cnt==255, so no PWM frame ever mixes two duty values.
- Beat timing at defaults (clocks from reset release):
  - duty reaches 255 at step 255, ≈21.8 ms.
  - duty returns to 0 at step 510.
  - duty reaches 192 at step 702.
  - duty returns to 0 at step 894.
  - RISE1 is re-entered at step 1150.
- Outputs never glitch. The only transitions are registered edges, at most two per PWM frame.

## Test plan
- Reset: hold rst_n=0 for 2 clk, then release. Required: led_out==8'h00 throughout reset and for the first 1024 clocks after release, because duty=0.
- First ramp: after step 1 (duty=1), led_out==8'hFF for exactly 1 clk per 256-clk frame. After step 128, it is lit for exactly 128 clk per frame. All 8 bits must always be equal.
- Beat envelope over 100 ms at defaults: sample duty at every step_tick.
  - Required: monotonic 0→255→0→192→0, then 256 steps at 0.
  - Required: RISE1 restarts at clock 1,177,600 (±1) after release.
- Peak/boundary: at the PEAK1 step, duty==255 and the frame shows 255 lit clocks and 1 dark clock. duty never reads 0 while in RISE states after the first step, and never underflows to 255 in FALL states.
- Mid-operation reset: assert rst_n=0 for 1 clk during FALL1 (duty≈200). Required: next led_out is unlit, state is RISE1, duty is 0, and the envelope restarts exactly as after power-up.
- Parameter override: set STEP_FRAMES=1, PEAK1=4, PEAK2=2, REST_STEPS=3, LED_ACTIVE_LOW=1.
  - Required: period = (8+4+3)·256 = 3840 clk.
  - Required: led_out is 8'hFF in reset and at duty 0, and lit pixels read 8'h00.
